// File: rtl/run_stuff_pkg.sv
// run_stuff_pkg
//   Shared types and default constants for the run-length stuffing
//   serial transmitter (run_stuff_tx).
//   - state_e     : transmitter FSM states
//   - DATA_W_DEF  : default parallel word width
//   - RUN_MAX_DEF : default longest run of equal line bits before a stuff bit
package run_stuff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // nothing pending, ready for a word
    DATA  = 2'd1,  // data bits of the current word remain
    STUFF = 2'd2   // a complementary stuff bit goes out next
  } state_e;

  localparam int DATA_W_DEF  = 8;
  localparam int RUN_MAX_DEF = 3;

endpackage

// File: rtl/run_stuff_tx.sv
// run_stuff_tx
//   Serial transmitter with run-length bit stuffing. Parallel words are
//   accepted over a valid/ready handshake and shifted out MSB-first. After
//   every RUN_MAX consecutive equal line bits a complementary stuff bit is
//   inserted, so the line never carries more than RUN_MAX equal bits in a row.
//
// Ports
//   clk         : rising-edge clock
//   reset_n     : asynchronous active-low reset
//   data_in     : word to transmit, sampled on an accepting edge
//   data_valid  : data_in holds a word
//   data_ready  : block can accept a word this cycle (state == IDLE)
//   w           : registered serial line bit
//   w_valid     : registered, w carries a data or stuff bit this cycle
module run_stuff_tx
  import run_stuff_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RUN_MAX = RUN_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              w,
  output logic              w_valid
);

  localparam int REM_W = $clog2(DATA_W + 1);
  localparam int RUN_W = $clog2(RUN_MAX + 1);

  state_e            state_q,    state_d;
  logic [DATA_W-1:0] sr_q,       sr_d;
  logic [REM_W-1:0]  rem_q,      rem_d;
  logic [RUN_W-1:0]  run_cnt_q,  run_cnt_d;
  logic              last_bit_q, last_bit_d;
  logic              w_q,        w_d;
  logic              w_valid_q,  w_valid_d;

  // Run length after putting bit b on the line. A zero count means the
  // history was cleared by an idle gap, so any bit starts a fresh run.
  function automatic logic [RUN_W-1:0] next_run(input logic [RUN_W-1:0] cnt,
                                                input logic             last,
                                                input logic             b);
    if (cnt != '0 && b == last) next_run = cnt + 1'b1;
    else                        next_run = RUN_W'(1);
  endfunction

  logic             emit;
  logic             emit_bit;
  logic [REM_W-1:0] rem_after;
  logic [RUN_W-1:0] run_after;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    rem_d      = rem_q;
    run_cnt_d  = run_cnt_q;
    last_bit_d = last_bit_q;
    w_d        = w_q;
    w_valid_d  = w_valid_q;
    emit       = 1'b0;
    emit_bit   = 1'b0;
    rem_after  = rem_q;
    run_after  = '0;

    case (state_q)
      IDLE: begin
        if (data_valid) begin
          emit      = 1'b1;
          emit_bit  = data_in[DATA_W-1];
          sr_d      = data_in << 1;
          rem_after = REM_W'(DATA_W - 1);
        end else begin
          // Line goes quiet; w keeps its last value, run history is dropped.
          w_valid_d = 1'b0;
          run_cnt_d = '0;
        end
      end
      DATA: begin
        emit      = 1'b1;
        emit_bit  = sr_q[DATA_W-1];
        sr_d      = sr_q << 1;
        rem_after = rem_q - 1'b1;
      end
      STUFF: begin
        w_d        = ~last_bit_q;
        w_valid_d  = 1'b1;
        last_bit_d = ~last_bit_q;
        run_cnt_d  = RUN_W'(1);
        state_d    = (rem_q != '0) ? DATA : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      run_after  = next_run(run_cnt_q, last_bit_q, emit_bit);
      w_d        = emit_bit;
      w_valid_d  = 1'b1;
      last_bit_d = emit_bit;
      run_cnt_d  = run_after;
      rem_d      = rem_after;
      // A full run forces a stuff bit even after the last data bit, which
      // keeps the block busy for one tail cycle.
      if (run_after == RUN_W'(RUN_MAX)) state_d = STUFF;
      else if (rem_after != '0)         state_d = DATA;
      else                              state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      rem_q      <= '0;
      run_cnt_q  <= '0;
      last_bit_q <= 1'b0;
      w_q        <= 1'b0;
      w_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      rem_q      <= rem_d;
      run_cnt_q  <= run_cnt_d;
      last_bit_q <= last_bit_d;
      w_q        <= w_d;
      w_valid_q  <= w_valid_d;
    end
  end

  assign data_ready = (state_q == IDLE);
  assign w          = w_q;
  assign w_valid    = w_valid_q;

endmodule
